pipe_skid_reg: RTL and testbench

Parametrised elastic pipeline stage register, the successor to the fixed-width stall/flush stage registers between RISC-V pipeline stages. It carries a DATA_W-bit payload (e.g. instr/PC/PC+4 bundle) under a valid/ready handshake. It optionally includes a one-entry skid buffer so that upstream ready is registered. It supports synchronous flush (bubble insertion on branch/jump) and counts back-pressure cycles for performance debug.

---
 rtl/pipe_skid_reg.sv | 119 +++++++++++
 tb/tb_pipe_skid_reg.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register with valid/ready handshake, optional one-entry
// skid buffer (registered in_ready), synchronous flush and a saturating stall counter.
module pipe_skid_reg #(
    parameter int unsigned DATA_W  = 96,
    parameter int unsigned SKID    = 1,
    parameter int unsigned STALL_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [1:0]         occupancy,
    output logic [STALL_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FULL      = 2'd1,
        ST_SKID_FULL = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   main_q, main_d;
    logic [DATA_W-1:0]   skid_q, skid_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic                rdy_q, rdy_d;
    logic                in_fire, out_fire;

    assign out_valid    = (state_q != ST_EMPTY);
    assign out_data     = main_q;
    assign stall_cycles = stall_q;

    // Skid mode exposes a registered ready so out_ready never reaches in_ready.
    always_comb begin
        if (SKID != 0) in_ready = rdy_q;
        else           in_ready = out_ready || !out_valid;
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_comb begin
        case (state_q)
            ST_EMPTY:     occupancy = 2'd0;
            ST_FULL:      occupancy = 2'd1;
            ST_SKID_FULL: occupancy = 2'd2;
            default:      occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid && !out_ready && (stall_q != '1)) begin
            stall_d = stall_q + STALL_W'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d = ST_FULL;
                    main_d  = in_data;
                end
            end
            ST_FULL: begin
                if (in_fire && out_fire) begin
                    main_d = in_data;
                end else if (in_fire) begin
                    state_d = ST_SKID_FULL;
                    skid_d  = in_data;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                    main_d  = '0;
                end
            end
            ST_SKID_FULL: begin
                if (out_fire) begin
                    state_d = ST_FULL;
                    main_d  = skid_q;
                    skid_d  = '0;
                end
            end
            default: begin
                state_d = ST_EMPTY;
                main_d  = '0;
                skid_d  = '0;
            end
        endcase

        // Flush and reset override any handshake decided above.
        if (reset || flush) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end
        if (reset) begin
            stall_d = '0;
        end

        rdy_d = (state_d != ST_SKID_FULL);
    end

    always_ff @(posedge clock) begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        stall_q <= stall_d;
        rdy_q   <= rdy_d;
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: three instances (skid, no-skid, 3-bit stall
// counter) share one stimulus stream and are compared against per-instance FIFO models.
module tb_pipe_skid_reg;

    localparam int unsigned DW = 96;

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;

    logic          rdy0, rdy1, rdy2;
    logic          ov0, ov1, ov2;
    logic [DW-1:0] od0, od1, od2;
    logic [1:0]    occ0, occ1, occ2;
    logic [15:0]   st0, st1;
    logic [2:0]    st_sat;

    int unsigned n_checks = 0;
    int unsigned n_err    = 0;

    // Reference model: each instance is a FIFO of bounded depth.
    logic [DW-1:0] mq   [3][2];
    int unsigned   mcnt [3];
    int unsigned   mst  [3];

    always #5 clock = ~clock;

    pipe_skid_reg #(.DATA_W(DW), .SKID(1), .STALL_W(16)) u_skid (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0), .stall_cycles(st0)
    );

    pipe_skid_reg #(.DATA_W(DW), .SKID(0), .STALL_W(16)) u_noskid (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(occ1), .stall_cycles(st1)
    );

    pipe_skid_reg #(.DATA_W(DW), .SKID(1), .STALL_W(3)) u_sat (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .occupancy(occ2), .stall_cycles(st_sat)
    );

    task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_ready(input int unsigned i);
        if (i == 1) return out_ready || (mcnt[i] == 0);
        return mcnt[i] < 2;
    endfunction

    function automatic int unsigned m_smax(input int unsigned i);
        return (i == 2) ? 7 : 65535;
    endfunction

    function automatic logic [DW-1:0] m_data(input int unsigned i);
        return (mcnt[i] > 0) ? mq[i][0] : '0;
    endfunction

    task automatic check_inst(input int unsigned i, input logic r, input logic v,
                              input logic [DW-1:0] d, input logic [1:0] o, input logic [15:0] s);
        check_eq($sformatf("u%0d.in_ready", i),     DW'(r), DW'(m_ready(i)));
        check_eq($sformatf("u%0d.out_valid", i),    DW'(v), DW'(mcnt[i] > 0));
        check_eq($sformatf("u%0d.out_data", i),     d,      m_data(i));
        check_eq($sformatf("u%0d.occupancy", i),    DW'(o), DW'(mcnt[i]));
        check_eq($sformatf("u%0d.stall_cycles", i), DW'(s), DW'(mst[i]));
    endtask

    task automatic model_update(input int unsigned i);
        bit r;
        bit fo;
        r  = m_ready(i);
        fo = (mcnt[i] > 0) && out_ready;
        if (reset) begin
            mcnt[i] = 0;
            mst[i]  = 0;
        end else begin
            if ((mcnt[i] > 0) && !out_ready && (mst[i] < m_smax(i))) mst[i]++;
            if (flush) begin
                mcnt[i] = 0;
            end else begin
                if (fo) begin
                    mq[i][0] = mq[i][1];
                    mcnt[i]--;
                end
                if (in_valid && r) begin
                    mq[i][mcnt[i]] = in_data;
                    mcnt[i]++;
                end
            end
        end
    endtask

    // One cycle: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        @(negedge clock);
        check_inst(0, rdy0, ov0, od0, occ0, st0);
        check_inst(1, rdy1, ov1, od1, occ1, st1);
        check_inst(2, rdy2, ov2, od2, occ2, {13'd0, st_sat});
        for (int unsigned i = 0; i < 3; i++) model_update(i);
        @(posedge clock);
        #1;
    endtask

    initial begin
        for (int unsigned i = 0; i < 3; i++) begin
            mcnt[i]  = 0;
            mst[i]   = 0;
            mq[i][0] = '0;
            mq[i][1] = '0;
        end

        // Reset with live input traffic.
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'hAB);
        out_ready = 1'b0;
        step();
        step();
        check_eq("reset.in_ready",  DW'(rdy0), DW'(1));
        check_eq("reset.out_valid", DW'(ov0),  DW'(0));
        check_eq("reset.out_data",  od0,       DW'(0));
        check_eq("reset.occupancy", DW'(occ0), DW'(0));
        check_eq("reset.stall",     DW'(st0),  DW'(0));

        // Streaming at full rate.
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int unsigned k = 1; k <= 3; k++) begin
            in_data = DW'(k);
            step();
            check_eq("stream.out_data", od0, DW'(k));
            check_eq("stream.in_ready", DW'(rdy0), DW'(1));
        end
        in_valid = 1'b0;
        step();
        step();

        // Back-pressure: skid fills, third word waits for space.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int unsigned k = 0; k < 3; k++) begin
            in_data = DW'(8'h10 + k);
            step();
            check_eq("bp.occupancy", DW'(occ0), DW'((k == 0) ? 1 : 2));
        end
        check_eq("bp.in_ready", DW'(rdy0), DW'(0));
        out_ready = 1'b1;
        check_eq("bp.first", od0, DW'(8'h10));
        step();
        check_eq("bp.second", od0, DW'(8'h11));
        check_eq("bp.ready_back", DW'(rdy0), DW'(1));
        step();
        check_eq("bp.third", od0, DW'(8'h12));
        in_valid = 1'b0;
        step();
        check_eq("bp.drained", DW'(ov0), DW'(0));
        check_eq("bp.stall", DW'(st0), DW'(2));

        // Flush while the skid is full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'hA0);
        step();
        in_data   = DW'(8'hA1);
        step();
        check_eq("flush.pre_occ", DW'(occ0), DW'(2));
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = DW'(8'hA2);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        check_eq("flush.occupancy", DW'(occ0), DW'(0));
        check_eq("flush.out_valid", DW'(ov0),  DW'(0));
        check_eq("flush.out_data",  od0,       DW'(0));
        check_eq("flush.in_ready",  DW'(rdy0), DW'(1));
        check_eq("flush.stall",     DW'(st0),  DW'(3));
        step();
        check_eq("flush.no_deliver", DW'(ov0), DW'(0));

        // Saturation of the 3-bit stall counter.
        reset = 1'b1;
        step();
        reset     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = DW'(8'h55);
        step();
        in_valid = 1'b0;
        for (int unsigned k = 0; k < 10; k++) step();
        check_eq("sat.stall3",  DW'(st_sat), DW'(7));
        check_eq("sat.stall16", DW'(st0),    DW'(10));

        // Randomized traffic including occasional flush and reset.
        for (int unsigned n = 0; n < 3000; n++) begin
            reset     = ($urandom_range(0, 63) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
